// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: control-bundle layout and register
// address constants used by the decode/execute boundary.
package rv32i_pkg;

  localparam int CTRL_W    = 16;
  localparam int MEMRD_BIT = 0;
  localparam int RD_W      = 5;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam logic [RD_W-1:0] X0 = '0;

endpackage

// File: rtl/id_ex_if.sv
// Decode-to-execute boundary bundle: decode-side handshake and fields,
// writeback bypass source, pipeline control and the registered execute view.
interface id_ex_if #(
  parameter int WIDTH  = 32,
  parameter int RD     = 5,
  parameter int CTRL_W = 16
);

  // id_valid_i/id_ready_o: the decode instruction moves into execute on a
  // rising clk_i edge where both are high; the producer holds every id_*
  // field stable while id_valid_i is high and id_ready_o is low, and
  // id_ready_o never waits on id_valid_i.
  logic              id_valid_i;
  logic              id_ready_o;
  logic [WIDTH-1:0]  id_pc_i;
  logic [RD-1:0]     id_rs1_addr_i;
  logic [RD-1:0]     id_rs2_addr_i;
  logic [RD-1:0]     id_rd_addr_i;
  logic [WIDTH-1:0]  id_rd1_i;
  logic [WIDTH-1:0]  id_rd2_i;
  logic [WIDTH-1:0]  id_imm_i;
  logic [CTRL_W-1:0] id_ctrl_i;

  logic              wb_we_i;
  logic [RD-1:0]     wb_addr_i;
  logic [WIDTH-1:0]  wb_data_i;

  logic              stall_i;
  logic              flush_i;

  logic              ex_valid_o;
  logic [WIDTH-1:0]  ex_pc_o;
  logic [WIDTH-1:0]  ex_imm_o;
  logic [WIDTH-1:0]  ex_rs1_data_o;
  logic [WIDTH-1:0]  ex_rs2_data_o;
  logic [RD-1:0]     ex_rs1_addr_o;
  logic [RD-1:0]     ex_rs2_addr_o;
  logic [RD-1:0]     ex_rd_addr_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [15:0]       bubble_cnt_o;

  modport master (
    output id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
           id_rd1_i, id_rd2_i, id_imm_i, id_ctrl_i,
           wb_we_i, wb_addr_i, wb_data_i, stall_i, flush_i,
    input  id_ready_o, ex_valid_o, ex_pc_o, ex_imm_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
           ex_ctrl_o, bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
           id_rd1_i, id_rd2_i, id_imm_i, id_ctrl_i,
           wb_we_i, wb_addr_i, wb_data_i, stall_i, flush_i,
    output id_ready_o, ex_valid_o, ex_pc_o, ex_imm_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
           ex_ctrl_o, bubble_cnt_o
  );

endinterface

// File: rtl/id_ex_bypass.sv
// Writeback bypass: substitutes same-cycle writeback data for a register
// operand whose address matches; x0 is never bypassed.
module id_ex_bypass
  import rv32i_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD    = 5
) (
  input  logic             wb_we,
  input  logic [RD-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [RD-1:0]    addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  logic hit;

  assign hit = wb_we && (wb_addr != RD'(X0)) && (wb_addr == addr);
  assign q   = hit ? wb_data : data;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with writeback bypass on capture,
// in-place operand patching while stalled, and load-use bubble insertion.
module id_ex_stage #(
  parameter int WIDTH     = 32,
  parameter int RD        = 5,
  parameter int CTRL_W    = rv32i_pkg::CTRL_W,
  parameter int MEMRD_BIT = rv32i_pkg::MEMRD_BIT
) (
  input  logic    clk_i,
  input  logic    rst_i,
  id_ex_if.slave  bus
);

  logic              valid_q;
  logic [WIDTH-1:0]  pc_q;
  logic [WIDTH-1:0]  imm_q;
  logic [WIDTH-1:0]  rs1_data_q;
  logic [WIDTH-1:0]  rs2_data_q;
  logic [RD-1:0]     rs1_addr_q;
  logic [RD-1:0]     rs2_addr_q;
  logic [RD-1:0]     rd_addr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [15:0]       bubble_cnt_q;

  logic [WIDTH-1:0]  cap_rs1;
  logic [WIDTH-1:0]  cap_rs2;
  logic [WIDTH-1:0]  hold_rs1;
  logic [WIDTH-1:0]  hold_rs2;
  logic              load_use;

  // Capture path: decode operands corrected by the writeback landing this cycle.
  id_ex_bypass #(.WIDTH(WIDTH), .RD(RD)) u_cap_rs1 (
    .wb_we(bus.wb_we_i), .wb_addr(bus.wb_addr_i), .wb_data(bus.wb_data_i),
    .addr(bus.id_rs1_addr_i), .data(bus.id_rd1_i), .q(cap_rs1)
  );

  id_ex_bypass #(.WIDTH(WIDTH), .RD(RD)) u_cap_rs2 (
    .wb_we(bus.wb_we_i), .wb_addr(bus.wb_addr_i), .wb_data(bus.wb_data_i),
    .addr(bus.id_rs2_addr_i), .data(bus.id_rd2_i), .q(cap_rs2)
  );

  // Hold path: a stalled instruction must still see writebacks that retire under it.
  id_ex_bypass #(.WIDTH(WIDTH), .RD(RD)) u_hold_rs1 (
    .wb_we(bus.wb_we_i), .wb_addr(bus.wb_addr_i), .wb_data(bus.wb_data_i),
    .addr(rs1_addr_q), .data(rs1_data_q), .q(hold_rs1)
  );

  id_ex_bypass #(.WIDTH(WIDTH), .RD(RD)) u_hold_rs2 (
    .wb_we(bus.wb_we_i), .wb_addr(bus.wb_addr_i), .wb_data(bus.wb_data_i),
    .addr(rs2_addr_q), .data(rs2_data_q), .q(hold_rs2)
  );

  // Both sources compared regardless of whether the opcode reads them.
  assign load_use = valid_q && ctrl_q[MEMRD_BIT] && (rd_addr_q != '0) &&
                    bus.id_valid_i &&
                    ((bus.id_rs1_addr_i == rd_addr_q) ||
                     (bus.id_rs2_addr_i == rd_addr_q));

  assign bus.id_ready_o = !rst_i && !bus.stall_i && !load_use;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      imm_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.flush_i) begin
      valid_q <= 1'b0;
    end else if (bus.stall_i) begin
      if (valid_q) begin
        rs1_data_q <= hold_rs1;
        rs2_data_q <= hold_rs2;
      end
    end else if (load_use) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
    end else begin
      valid_q    <= bus.id_valid_i;
      pc_q       <= bus.id_pc_i;
      imm_q      <= bus.id_imm_i;
      rs1_data_q <= cap_rs1;
      rs2_data_q <= cap_rs2;
      rs1_addr_q <= bus.id_rs1_addr_i;
      rs2_addr_q <= bus.id_rs2_addr_i;
      rd_addr_q  <= bus.id_rd_addr_i;
      ctrl_q     <= bus.id_valid_i ? bus.id_ctrl_i : '0;
    end
  end

  assign bus.ex_valid_o    = valid_q;
  assign bus.ex_pc_o       = pc_q;
  assign bus.ex_imm_o      = imm_q;
  assign bus.ex_rs1_data_o = rs1_data_q;
  assign bus.ex_rs2_data_o = rs2_data_q;
  assign bus.ex_rs1_addr_o = rs1_addr_q;
  assign bus.ex_rs2_addr_o = rs2_addr_q;
  assign bus.ex_rd_addr_o  = rd_addr_q;
  assign bus.ex_ctrl_o     = ctrl_q;
  assign bus.bubble_cnt_o  = bubble_cnt_q;

endmodule
